tone_bank: RTL and testbench
============================

// Module: tone_bank
// PURPOSE
//  Parametrised N-channel square-wave tone generator; successor to the fixed per-note divider modules.
//  Each channel has a run-time programmable half-period, a 50% duty output and phase restart on key press.
//  Provides per-channel tones, a polyphonic mix count and a lowest-key mono output.
//  Sits between the input conditioners / key LUT and the LFSR / speaker stage.
// PARAMETERS
//  N_CH      8    number of tone channels (1..16)
//  CNT_W     17   half-period counter width, in bits
//  CH_W      3    channel address width, $clog2(N_CH)
//  MIX_W     4    mix count width, $clog2(N_CH+1)
// PORTS
//  clk       in   1           system clock (50 MHz nominal)
//  rst_n     in   1           asynchronous active-low reset
//  key       in   N_CH        conditioned key levels; bit i gates channel i
//  cfg_we    in   1           half-period write strobe (single cycle)
//  cfg_ch    in   CH_W        channel written when cfg_we=1
//  cfg_half  in   CNT_W       new half-period, in clk cycles
//  tone      out  N_CH        per-channel square wave
//  active    out  N_CH        registered copy of key
//  mix       out  MIX_W       number of channels with tone=1
//  mono      out  1           tone of lowest-index active channel; 0 if none active
// BEHAVIOUR
//  Reset (async, rst_n=0): counters=0, tone=0, active=0, mix=0, mono=0.
//   Half-period regs load DEFAULT_HALF[i] (C4..C5: 95566,85121,75850,71592,63776,56818,50618,47774).
//  Key sampling: active <= key every cycle. Rising edge = key[i] & ~active[i].
//  Rising edge: counter_i <= 0, tone_i <= 0 (phase restart). No toggle on that cycle.
//  Running (active[i]=1, not a rising edge): counter_i increments.
//   When counter_i >= eff_half_i-1: counter_i <= 0, tone_i toggles.
//   Use >=, not ==, so a shrunk half-period wraps next cycle instead of running to 2^CNT_W.
//  eff_half = max(half_reg,1). Value 0 behaves as 1, giving a toggle every cycle (period 2 clk).
//  Key released (active[i]=0): counter_i held 0, tone_i forced 0 on the next edge.
//  Output period = 2*eff_half clk cycles at exactly 50% duty.
//  Write (cfg_we=1): half_reg[cfg_ch] <= cfg_half. The compare in the same cycle still uses the old value.
//   The new value governs from the next cycle. Writes with cfg_ch >= N_CH are ignored.
//  Writes do not reset the phase. A write to an idle channel is stored for its next press.
//  Latency: key high at edge k gives active=1 after k. The counter runs from 0 at k+1.
//   The first tone rise occurs eff_half cycles after that.
//  mix <= popcount(tone), registered; lags tone by 1 cycle.
//  mono <= tone[j] for the lowest j with active[j]=1, registered (1 cycle lag); 0 when active==0.
//  Simultaneous press of several keys: all restart independently.
//  A press on the same cycle as a wrap: the restart wins.
//  A mid-operation reset returns all state to the reset values, including DEFAULT_HALF.
// STRUCTURE
//  Package tone_pkg holds:
//   - CNT_W default;
//   - DEFAULT_HALF localparam array (half-periods at 50 MHz);
//   - the note-index enum C4, D4, E4, F4, G4, A4, B4, C5.
//  Sub-module tone_channel is generated N_CH times. It contains half_reg, counter, tone, key edge detect.
//   Ports: clk, rst_n, key, we, wdata, default_half, tone.
//  Top level: write decode, popcount, lowest-active priority encoder, mix/mono registers.
// TESTING
//  1. Reset then idle: key=0 for 1000 cycles -> tone=0, mix=0, mono=0.
//     Readback shows half_reg[0]=95566 (hierarchical check).
//  2. Write ch0 half=4, key[0]=1 held -> active rises after 1 edge.
//     tone[0] then has period 8, high 4, low 4. mix toggles 0/1 with 1-cycle lag.
//  3. Phase restart: ch1 half=5, key[1] dropped and re-raised mid-high phase.
//     -> tone[1]=0 and the counter restarts; the next rise is 5 cycles later.
//  4. Shrink on the fly: ch2 half=100 running, counter near 60, write half=10.
//     -> wraps next cycle and then holds period 20. Half=0 gives period 2.
//  5. Polyphony/mono: ch3 half=3, ch5 half=7, key=8'b0010_1000.
//     -> mix reaches 2 when both are high; mono follows tone[3].
//     Release key[3] -> mono follows tone[5]. Release all -> mono=0.
//  6. Async reset mid-run: rst_n low between edges -> all outputs 0 immediately.
//     Half regs revert to defaults; after rst_n high with key[0]=1, the period is 191132.

Source files
------------

// File: rtl/tone_pkg.sv
// Shared constants for the tone bank: counter width default, note names and
// the reset half-periods (C4..C5 at 50 MHz).
package tone_pkg;

    localparam int unsigned CNT_W_DEF = 17;
    localparam int unsigned N_NOTES   = 8;
    localparam int unsigned NOTE_W    = 3;

    typedef enum logic [NOTE_W-1:0] {
        C4, D4, E4, F4, G4, A4, B4, C5
    } note_e;

    // Half-period in clk cycles for each note, indexed by note_e
    localparam logic [CNT_W_DEF-1:0] DEFAULT_HALF [N_NOTES] = '{
        17'd95566, 17'd85121, 17'd75850, 17'd71592,
        17'd63776, 17'd56818, 17'd50618, 17'd47774
    };

    // Channels beyond the eighth reuse the scale from C4 upward
    function automatic logic [CNT_W_DEF-1:0] default_half_f(input int unsigned ch);
        return DEFAULT_HALF[NOTE_W'(ch % N_NOTES)];
    endfunction

endpackage

// File: rtl/tone_bank_if.sv
// Key/config inputs and tone/mix/mono outputs of the tone bank.
interface tone_bank_if #(
    parameter int unsigned N_CH  = 8,
    parameter int unsigned CNT_W = 17,
    parameter int unsigned CH_W  = 3,
    parameter int unsigned MIX_W = 4
);

    logic [N_CH-1:0]  key;
    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_half;
    logic [N_CH-1:0]  tone;
    logic [N_CH-1:0]  active;
    logic [MIX_W-1:0] mix;
    logic             mono;

    modport master (
        output key, cfg_we, cfg_ch, cfg_half,
        input  tone, active, mix, mono
    );

    modport slave (
        input  key, cfg_we, cfg_ch, cfg_half,
        output tone, active, mix, mono
    );

endinterface

// File: rtl/tone_channel.sv
// One square-wave channel: programmable half-period, key edge detect and
// phase restart on press.
module tone_channel #(
    parameter int unsigned CNT_W = tone_pkg::CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key,
    input  logic             we,
    input  logic [CNT_W-1:0] wdata,
    input  logic [CNT_W-1:0] default_half,
    output logic             tone,
    output logic             active
);

    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] wrap_at;
    logic             tone_q, tone_d;
    logic             active_q;
    logic             rise;

    // A programmed half-period of 0 behaves as 1
    assign wrap_at = (half_q == '0) ? '0 : half_q - CNT_W'(1);
    assign rise    = key & ~active_q;

    always_comb begin
        half_d = half_q;
        cnt_d  = cnt_q;
        tone_d = tone_q;
        if (we) begin
            half_d = wdata;
        end
        // Restart/idle take priority; >= lets a shrunk half-period wrap at once
        if (rise || !active_q) begin
            cnt_d  = '0;
            tone_d = 1'b0;
        end else if (cnt_q >= wrap_at) begin
            cnt_d  = '0;
            tone_d = ~tone_q;
        end else begin
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_q   <= default_half;
            cnt_q    <= '0;
            tone_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            half_q   <= half_d;
            cnt_q    <= cnt_d;
            tone_q   <= tone_d;
            active_q <= key;
        end
    end

    assign tone   = tone_q;
    assign active = active_q;

endmodule

// File: rtl/tone_bank.sv
// N-channel square-wave tone bank with polyphonic mix count and a
// lowest-key mono output.
module tone_bank
    import tone_pkg::*;
#(
    parameter int unsigned N_CH  = 8,
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned CH_W  = 3,
    parameter int unsigned MIX_W = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    tone_bank_if.slave bus
);

    logic [N_CH-1:0]  tone_w;
    logic [N_CH-1:0]  active_w;
    logic [MIX_W-1:0] mix_d, mix_q;
    logic             mono_d, mono_q;

    // Writes addressed past the last channel match no decoder and are dropped
    for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
        localparam logic [CNT_W-1:0] DFLT = CNT_W'(default_half_f(i));
        logic we;

        assign we = bus.cfg_we && (bus.cfg_ch == CH_W'(i));

        tone_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .key          (bus.key[i]),
            .we           (we),
            .wdata        (bus.cfg_half),
            .default_half (DFLT),
            .tone         (tone_w[i]),
            .active       (active_w[i])
        );
    end

    // Popcount of tones and tone of the lowest-index active channel
    always_comb begin
        logic found;
        mix_d  = '0;
        mono_d = 1'b0;
        found  = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            mix_d = mix_d + MIX_W'(tone_w[i]);
            if (active_w[i] && !found) begin
                mono_d = tone_w[i];
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mix_q  <= '0;
            mono_q <= 1'b0;
        end else begin
            mix_q  <= mix_d;
            mono_q <= mono_d;
        end
    end

    assign bus.tone   = tone_w;
    assign bus.active = active_w;
    assign bus.mix    = mix_q;
    assign bus.mono   = mono_q;

endmodule

// File: tb/tb_tone_bank.sv
// Directed checks of the tone bank: reset, period, restart, shrink,
// polyphony/mono and asynchronous reset.
module tb_tone_bank;

    logic clk;
    logic rst_n;
    int   passed;
    int   total;

    tone_bank_if #(.N_CH(8), .CNT_W(17), .CH_W(3), .MIX_W(4)) bus ();

    tone_bank #(.N_CH(8), .CNT_W(17), .CH_W(3), .MIX_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected square wave m edges after a press with half-period h
    function automatic logic sq(input int m, input int h);
        return ((m / h) % 2) != 0;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int ch, input int half);
        bus.cfg_we   = 1'b1;
        bus.cfg_ch   = 3'(ch);
        bus.cfg_half = 17'(half);
        tick(1);
        bus.cfg_we   = 1'b0;
    endtask

    task automatic test_reset;
        int bad;
        rst_n        = 1'b0;
        bus.key      = '0;
        bus.cfg_we   = 1'b0;
        bus.cfg_ch   = '0;
        bus.cfg_half = '0;
        #12;
        total++; if (bus.tone !== 8'h00) $display("FAIL reset_tone got %h want 00", bus.tone); else passed++;
        total++; if (bus.active !== 8'h00) $display("FAIL reset_active got %h want 00", bus.active); else passed++;
        total++; if (bus.mix !== 4'd0) $display("FAIL reset_mix got %0d want 0", bus.mix); else passed++;
        total++; if (bus.mono !== 1'b0) $display("FAIL reset_mono got %b want 0", bus.mono); else passed++;
        total++; if (dut.g_ch[0].u_ch.half_q !== 17'd95566) $display("FAIL reset_half0 got %0d want 95566", dut.g_ch[0].u_ch.half_q); else passed++;
        total++; if (dut.g_ch[7].u_ch.half_q !== 17'd47774) $display("FAIL reset_half7 got %0d want 47774", dut.g_ch[7].u_ch.half_q); else passed++;
        rst_n = 1'b1;
        bad = 0;
        repeat (1000) begin
            tick(1);
            if (bus.tone !== 8'h00 || bus.mix !== 4'd0 || bus.mono !== 1'b0) bad++;
        end
        total++; if (bad !== 0) $display("FAIL idle_quiet got %0d bad cycles want 0", bad); else passed++;
    endtask

    task automatic test_period;
        cfg_write(0, 4);
        bus.key = 8'h01;
        tick(1);
        total++; if (bus.active[0] !== 1'b1) $display("FAIL per_active got %b want 1", bus.active[0]); else passed++;
        total++; if (bus.tone[0] !== 1'b0) $display("FAIL per_tone0 got %b want 0", bus.tone[0]); else passed++;
        for (int m = 1; m <= 16; m++) begin
            tick(1);
            total++; if (bus.tone[0] !== sq(m, 4)) $display("FAIL per_tone m=%0d got %b want %b", m, bus.tone[0], sq(m, 4)); else passed++;
            total++; if (bus.mix !== 4'(sq(m - 1, 4))) $display("FAIL per_mix m=%0d got %0d want %0d", m, bus.mix, sq(m - 1, 4)); else passed++;
            total++; if (bus.mono !== sq(m - 1, 4)) $display("FAIL per_mono m=%0d got %b want %b", m, bus.mono, sq(m - 1, 4)); else passed++;
        end
        bus.key = '0;
        tick(3);
        total++; if (bus.tone !== 8'h00) $display("FAIL per_release_tone got %h want 00", bus.tone); else passed++;
        total++; if (bus.mix !== 4'd0) $display("FAIL per_release_mix got %0d want 0", bus.mix); else passed++;
    endtask

    task automatic test_restart;
        cfg_write(1, 5);
        bus.key = 8'h02;
        tick(1);
        for (int m = 1; m <= 6; m++) begin
            tick(1);
            total++; if (bus.tone[1] !== sq(m, 5)) $display("FAIL rs_run m=%0d got %b want %b", m, bus.tone[1], sq(m, 5)); else passed++;
        end
        bus.key = 8'h00;
        tick(1);
        total++; if (bus.active[1] !== 1'b0) $display("FAIL rs_drop_active got %b want 0", bus.active[1]); else passed++;
        total++; if (bus.tone[1] !== 1'b1) $display("FAIL rs_drop_tone got %b want 1", bus.tone[1]); else passed++;
        bus.key = 8'h02;
        tick(1);
        total++; if (bus.tone[1] !== 1'b0) $display("FAIL rs_press_tone got %b want 0", bus.tone[1]); else passed++;
        total++; if (bus.active[1] !== 1'b1) $display("FAIL rs_press_active got %b want 1", bus.active[1]); else passed++;
        for (int m = 1; m <= 5; m++) begin
            tick(1);
            total++; if (bus.tone[1] !== sq(m, 5)) $display("FAIL rs_again m=%0d got %b want %b", m, bus.tone[1], sq(m, 5)); else passed++;
        end
        bus.key = '0;
        tick(3);
    endtask

    task automatic test_shrink;
        cfg_write(2, 100);
        bus.key = 8'h04;
        tick(1);
        tick(60);
        total++; if (bus.tone[2] !== 1'b0) $display("FAIL sh_before got %b want 0", bus.tone[2]); else passed++;
        bus.cfg_we   = 1'b1;
        bus.cfg_ch   = 3'd2;
        bus.cfg_half = 17'd10;
        tick(1);
        bus.cfg_we   = 1'b0;
        total++; if (bus.tone[2] !== 1'b0) $display("FAIL sh_old_cmp got %b want 0", bus.tone[2]); else passed++;
        total++; if (dut.g_ch[2].u_ch.cnt_q !== 17'd61) $display("FAIL sh_cnt got %0d want 61", dut.g_ch[2].u_ch.cnt_q); else passed++;
        tick(1);
        total++; if (bus.tone[2] !== 1'b1) $display("FAIL sh_wrap got %b want 1", bus.tone[2]); else passed++;
        for (int m = 1; m <= 30; m++) begin
            tick(1);
            total++; if (bus.tone[2] !== ~sq(m, 10)) $display("FAIL sh_p20 m=%0d got %b want %b", m, bus.tone[2], ~sq(m, 10)); else passed++;
        end
        bus.key = '0;
        tick(3);
        cfg_write(2, 0);
        bus.key = 8'h04;
        tick(1);
        for (int m = 1; m <= 6; m++) begin
            tick(1);
            total++; if (bus.tone[2] !== sq(m, 1)) $display("FAIL sh_zero m=%0d got %b want %b", m, bus.tone[2], sq(m, 1)); else passed++;
            total++; if (bus.mix !== 4'(sq(m - 1, 1))) $display("FAIL sh_zero_mix m=%0d got %0d want %0d", m, bus.mix, sq(m - 1, 1)); else passed++;
        end
        bus.key = '0;
        tick(3);
    endtask

    task automatic test_poly_mono;
        int  exp_mix;
        logic exp_mono;
        bit  saw2;
        saw2 = 1'b0;
        cfg_write(3, 3);
        cfg_write(5, 7);
        bus.key = 8'b0010_1000;
        tick(1);
        for (int m = 1; m <= 42; m++) begin
            tick(1);
            exp_mix = int'(sq(m - 1, 3)) + int'(sq(m - 1, 7));
            total++; if (bus.tone[3] !== sq(m, 3)) $display("FAIL pm_t3 m=%0d got %b want %b", m, bus.tone[3], sq(m, 3)); else passed++;
            total++; if (bus.tone[5] !== sq(m, 7)) $display("FAIL pm_t5 m=%0d got %b want %b", m, bus.tone[5], sq(m, 7)); else passed++;
            total++; if (bus.mix !== 4'(exp_mix)) $display("FAIL pm_mix m=%0d got %0d want %0d", m, bus.mix, exp_mix); else passed++;
            total++; if (bus.mono !== sq(m - 1, 3)) $display("FAIL pm_mono3 m=%0d got %b want %b", m, bus.mono, sq(m - 1, 3)); else passed++;
            if (bus.mix === 4'd2) saw2 = 1'b1;
        end
        total++; if (saw2 !== 1'b1) $display("FAIL pm_mix2 got %b want 1", saw2); else passed++;
        bus.key = 8'b0010_0000;
        for (int m = 43; m <= 60; m++) begin
            tick(1);
            exp_mono = (m == 43) ? sq(42, 3) : sq(m - 1, 7);
            total++; if (bus.mono !== exp_mono) $display("FAIL pm_mono5 m=%0d got %b want %b", m, bus.mono, exp_mono); else passed++;
        end
        total++; if (bus.active !== 8'b0010_0000) $display("FAIL pm_active got %b want 00100000", bus.active); else passed++;
        bus.key = '0;
        tick(3);
        total++; if (bus.mono !== 1'b0) $display("FAIL pm_off_mono got %b want 0", bus.mono); else passed++;
        total++; if (bus.mix !== 4'd0) $display("FAIL pm_off_mix got %0d want 0", bus.mix); else passed++;
        total++; if (bus.tone !== 8'h00) $display("FAIL pm_off_tone got %h want 00", bus.tone); else passed++;
        total++; if (bus.active !== 8'h00) $display("FAIL pm_off_active got %h want 00", bus.active); else passed++;
    endtask

    task automatic test_async_reset;
        cfg_write(0, 4);
        bus.key = 8'h01;
        tick(1);
        tick(5);
        total++; if (bus.tone[0] !== 1'b1) $display("FAIL ar_pre_tone got %b want 1", bus.tone[0]); else passed++;
        #3 rst_n = 1'b0;
        #1;
        total++; if (bus.tone !== 8'h00) $display("FAIL ar_tone got %h want 00", bus.tone); else passed++;
        total++; if (bus.active !== 8'h00) $display("FAIL ar_active got %h want 00", bus.active); else passed++;
        total++; if (bus.mix !== 4'd0) $display("FAIL ar_mix got %0d want 0", bus.mix); else passed++;
        total++; if (bus.mono !== 1'b0) $display("FAIL ar_mono got %b want 0", bus.mono); else passed++;
        total++; if (dut.g_ch[0].u_ch.half_q !== 17'd95566) $display("FAIL ar_half0 got %0d want 95566", dut.g_ch[0].u_ch.half_q); else passed++;
        total++; if (dut.g_ch[3].u_ch.half_q !== 17'd71592) $display("FAIL ar_half3 got %0d want 71592", dut.g_ch[3].u_ch.half_q); else passed++;
        #1 rst_n = 1'b1;
        tick(1);
        total++; if (bus.active[0] !== 1'b1) $display("FAIL ar_press_active got %b want 1", bus.active[0]); else passed++;
        total++; if (bus.tone[0] !== 1'b0) $display("FAIL ar_press_tone got %b want 0", bus.tone[0]); else passed++;
        tick(100);
        total++; if (dut.g_ch[0].u_ch.cnt_q !== 17'd100) $display("FAIL ar_cnt got %0d want 100", dut.g_ch[0].u_ch.cnt_q); else passed++;
        total++; if (bus.tone[0] !== 1'b0) $display("FAIL ar_run_tone got %b want 0", bus.tone[0]); else passed++;
        bus.key = '0;
        tick(3);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_period();
        test_restart();
        test_shrink();
        test_poly_mono();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
